// File: rtl/rfphoenix_vec_alu_mc.sv
// Multi-cycle lane-grouped vector ALU: LPC lanes per clock over NLANES/LPC cycles,
// with lane masking, packed compares, cross-lane reductions and kill.
module rfphoenix_vec_alu_mc #(
  parameter int NLANES = 16,
  parameter int WID    = 32,
  parameter int LPC    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [3:0]              op_i,
  input  logic                    pack_i,
  input  logic [NLANES-1:0]       mask_i,
  input  logic [NLANES*WID-1:0]   a_i,
  input  logic [NLANES*WID-1:0]   b_i,
  input  logic [NLANES*WID-1:0]   t_i,
  input  logic                    kill_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [NLANES*WID-1:0]   res_o,
  output logic                    busy_o
);
  localparam int G  = NLANES / LPC;
  localparam int KW = $clog2(G + 1);
  localparam int IW = $clog2(NLANES);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_EQ = 4'd5, OP_LT = 4'd6, OP_LTU = 4'd7;
  localparam logic [3:0] OP_RADD = 4'd8, OP_RMAX = 4'd9, OP_SHUF = 4'd10;
  localparam logic [WID-1:0] MIN_S = {1'b1, {(WID-1){1'b0}}};

  // Handshake: a request transfers on a clock edge where req_valid_i && req_ready_o;
  // a result transfers where res_valid_o && res_ready_i && !kill_i.
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;

  logic [KW-1:0]     k_q;
  logic [3:0]        op_q;
  logic              pack_q;
  logic [NLANES-1:0] mask_q, pmask_q, pmask_d;
  logic [WID-1:0]    a_q [NLANES];
  logic [WID-1:0]    b_q [NLANES];
  logic [WID-1:0]    t_q [NLANES];
  logic [WID-1:0]    res_q [NLANES];
  logic [WID-1:0]    acc_q, acc_d;
  logic [IW-1:0]     li [LPC];
  logic [WID-1:0]    gv [LPC];
  logic              is_cmp, is_red, fin;
  logic [WID-1:0]    fin_val;

  assign is_cmp  = (op_q == OP_EQ) || (op_q == OP_LT) || (op_q == OP_LTU);
  assign is_red  = (op_q == OP_RADD) || (op_q == OP_RMAX);
  assign fin     = (k_q == KW'(G));
  assign fin_val = is_red ? acc_q : WID'(pmask_q);

  // Lane datapath for the current group of LPC lanes.
  always_comb begin
    logic [WID-1:0] av, bv, tv, alu;
    logic act, c;
    acc_d   = acc_q;
    pmask_d = pmask_q;
    for (int j = 0; j < LPC; j++) begin
      li[j] = IW'(k_q) * IW'(LPC) + IW'(j);
      av    = a_q[li[j]];
      bv    = b_q[li[j]];
      tv    = t_q[li[j]];
      act   = mask_q[li[j]];
      c     = 1'b0;
      case (op_q)
        OP_EQ:   c = (av == bv);
        OP_LT:   c = ($signed(av) < $signed(bv));
        OP_LTU:  c = (av < bv);
        default: c = 1'b0;
      endcase
      case (op_q)
        OP_ADD:  alu = av + bv;
        OP_SUB:  alu = av - bv;
        OP_AND:  alu = av & bv;
        OP_OR:   alu = av | bv;
        OP_XOR:  alu = av ^ bv;
        OP_EQ, OP_LT, OP_LTU: alu = WID'(c);
        OP_SHUF: alu = a_q[bv[IW-1:0]];
        default: alu = av;
      endcase
      gv[j] = act ? alu : tv;
      if (is_cmp && pack_q) gv[j] = '0;
      if (is_red) gv[j] = tv;
      pmask_d[li[j]] = act & c;
      if (act && op_q == OP_RADD) acc_d = acc_d + av;
      if (act && op_q == OP_RMAX && $signed(av) > $signed(acc_d)) acc_d = av;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = EXEC;
      EXEC:    if (kill_i) state_d = IDLE; else if (fin) state_d = DONE;
      DONE:    if (kill_i || res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q     <= '0;
      op_q    <= '0;
      pack_q  <= 1'b0;
      mask_q  <= '0;
      pmask_q <= '0;
      acc_q   <= '0;
      for (int n = 0; n < NLANES; n++) begin
        a_q[n]   <= '0;
        b_q[n]   <= '0;
        t_q[n]   <= '0;
        res_q[n] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          op_q    <= op_i;
          pack_q  <= pack_i;
          mask_q  <= mask_i;
          k_q     <= '0;
          pmask_q <= '0;
          acc_q   <= (op_i == OP_RMAX) ? MIN_S : '0;
          for (int n = 0; n < NLANES; n++) begin
            a_q[n] <= a_i[n*WID +: WID];
            b_q[n] <= b_i[n*WID +: WID];
            t_q[n] <= t_i[n*WID +: WID];
          end
        end
        EXEC: if (!kill_i) begin
          if (!fin) begin
            for (int j = 0; j < LPC; j++) res_q[li[j]] <= gv[j];
            acc_q   <= acc_d;
            pmask_q <= pmask_d;
            k_q     <= k_q + KW'(1);
          end else if (is_red || (is_cmp && pack_q)) begin
            // Final cycle: lane 0 takes the folded reduction or packed bitmask.
            res_q[0] <= fin_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    res_o = '0;
    for (int n = 0; n < NLANES; n++) res_o[n*WID +: WID] = res_q[n];
  end

  assign req_ready_o = (state_q == IDLE);
  assign res_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
endmodule
